// File: rtl/vga_map_pkg.sv
// Shared definitions for the VGA tile-map fetch scheduler.
//   MAP_AW / MAP_DW : map-memory address and data widths
//   mapState_t      : scheduler FSM encoding
package vga_map_pkg;

    localparam int MAP_AW = 16;
    localparam int MAP_DW = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        READY = 3'd2,
        FETCH = 3'd3,
        DRAIN = 3'd4
    } mapState_t;

endpackage

// File: rtl/seq_mul16.sv
// 16x16 sequential shift-add multiplier, product truncated to 16 bits.
//   clk, reset    : clock, async active-high reset
//   start         : loads operands and (re)starts; wins over a run in progress
//   multiplicand  : operand A, captured on start
//   multiplier    : operand B, captured on start
//   done          : high in the 16th cycle after start
//   product       : A*B mod 2^16, valid only while done is high
module seq_mul16
    import vga_map_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MAP_DW-1:0] multiplicand,
    input  logic [MAP_DW-1:0] multiplier,
    output logic              done,
    output logic [MAP_DW-1:0] product
);

    logic              running;
    logic [3:0]        stepCnt;
    logic [MAP_DW-1:0] acc;
    logic [MAP_DW-1:0] mcand;
    logic [MAP_DW-1:0] mplier;
    logic [MAP_DW-1:0] accNext;

    always_comb begin
        accNext = acc;
        if (mplier[0]) begin
            accNext = acc + mcand;
        end
    end

    // The last partial product is folded in combinationally so the result
    // is available in the 16th cycle instead of one cycle later.
    assign done    = running && (stepCnt == 4'd15);
    assign product = accNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            stepCnt <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            stepCnt <= '0;
            acc     <= '0;
            mcand   <= multiplicand;
            mplier  <= multiplier;
        end else if (running) begin
            acc     <= accNext;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            stepCnt <= stepCnt + 4'd1;
            if (stepCnt == 4'd15) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vga_map_fetch_sched.sv
// VGA tile-map fetch scheduler. Latches the scroll registers once per frame,
// computes the display start location, bursts TILES_X map words per tile row
// into the line buffer and shares the single map-memory port with the CPU
// (VGA has priority during a burst, with a CPU starvation guard).
//
// Optional build macro VGA_MAP_HWRAP_EN: column pointer wraps within the
// level row (line origin = level + y*row_length, column starts at x_offset).
//
// Ports:
//   clk, reset          clock, async active-high reset
//   frame_start         1-cycle pulse, vertical blank start (aborts anything)
//   row_req             1-cycle pulse, prefetch next tile row
//   level_addr          level map base address
//   row_length          map words per level row
//   x_offset, y_offset  scroll, in tiles
//   cpu_req, cpu_addr   CPU port request / address
//   cpu_gnt             CPU owns the port this cycle (combinational)
//   mem_addr            shared memory address (combinational)
//   mem_rdata           read data, one cycle after address
//   tile_wr_en/idx/data line-buffer write port
//   start_addr          latched display start location
//   row_ready           1-cycle pulse once a row is fully written
//   busy                high in MUL, FETCH, DRAIN
//   overrun             sticky, row_req seen outside READY
//
// state | meaning
// IDLE  | waiting for frame_start
// MUL   | computing y_offset*row_length (16 cycles)
// READY | start location known, waiting for row_req
// FETCH | issuing TILES_X map reads for one tile row
// DRAIN | capturing the last word of the row
module vga_map_fetch_sched
    import vga_map_pkg::*;
#(
    parameter int TILES_X    = 40,
    parameter int TILES_Y    = 30,
    parameter int CPU_STARVE = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              row_req,
    input  logic [MAP_AW-1:0] level_addr,
    input  logic [MAP_AW-1:0] row_length,
    input  logic [MAP_AW-1:0] x_offset,
    input  logic [MAP_AW-1:0] y_offset,
    input  logic              cpu_req,
    input  logic [MAP_AW-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic [MAP_AW-1:0] mem_addr,
    input  logic [MAP_DW-1:0] mem_rdata,
    output logic              tile_wr_en,
    output logic [5:0]        tile_wr_idx,
    output logic [MAP_DW-1:0] tile_wr_data,
    output logic [MAP_AW-1:0] start_addr,
    output logic              row_ready,
    output logic              busy,
    output logic              overrun
);

    localparam int CNT_W = $clog2(CPU_STARVE + 1);
    localparam int ROW_W = $clog2(TILES_Y + 1);
    localparam logic [5:0]       LAST_COL   = 6'(TILES_X - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(TILES_Y - 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(CPU_STARVE);

    mapState_t         state;
    mapState_t         nextState;

    logic [MAP_AW-1:0] levelL;
    logic [MAP_AW-1:0] rowLenL;
    logic [MAP_AW-1:0] xL;
    logic [MAP_AW-1:0] startAddrQ;
    logic [MAP_AW-1:0] rowBase;
    logic [ROW_W-1:0]  rowCnt;
    logic [5:0]        col;
    logic [CNT_W-1:0]  denyCnt;
    logic              wrPend;
    logic [5:0]        wrIdx;
    logic              rowReadyQ;
    logic              overrunQ;

    logic              mulDone;
    logic [MAP_DW-1:0] mulProduct;
    logic [MAP_AW-1:0] startSum;
    logic [MAP_AW-1:0] vgaAddr;
    logic              cpuGnt;
    logic              vgaIssue;

    // y_offset and row_length are captured by the multiplier itself on
    // frame_start, so no separate y register is kept here.
    seq_mul16 uMul (
        .clk          (clk),
        .reset        (reset),
        .start        (frame_start),
        .multiplicand (row_length),
        .multiplier   (y_offset),
        .done         (mulDone),
        .product      (mulProduct)
    );

    assign startSum = levelL + xL + mulProduct;

`ifdef VGA_MAP_HWRAP_EN
    logic [MAP_AW-1:0] colPtr;
    logic [MAP_AW-1:0] lineOrigin;

    assign lineOrigin = levelL + mulProduct;
    assign vgaAddr    = rowBase + colPtr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colPtr <= '0;
        end else if (!frame_start) begin
            if (state == READY && row_req) begin
                colPtr <= xL;
            end else if (vgaIssue) begin
                if (colPtr == rowLenL - 16'd1) begin
                    colPtr <= '0;
                end else begin
                    colPtr <= colPtr + 16'd1;
                end
            end
        end
    end
`else
    assign vgaAddr = rowBase + MAP_AW'(col);
`endif

    // Arbitration: CPU always wins outside FETCH; inside FETCH only after
    // CPU_STARVE consecutive denied request cycles.
    assign cpuGnt   = cpu_req && ((state != FETCH) || (denyCnt == STARVE_MAX));
    // A frame_start cycle never counts as an issue, so an aborted burst
    // leaves nothing in the write pipeline.
    assign vgaIssue = (state == FETCH) && !cpuGnt && !frame_start;

    assign cpu_gnt      = cpuGnt;
    assign mem_addr     = cpuGnt ? cpu_addr : vgaAddr;
    assign tile_wr_en   = wrPend;
    assign tile_wr_idx  = wrIdx;
    assign tile_wr_data = mem_rdata;
    assign start_addr   = startAddrQ;
    assign row_ready    = rowReadyQ;
    assign busy         = (state == MUL) || (state == FETCH) || (state == DRAIN);
    assign overrun      = overrunQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (frame_start) begin
            nextState = MUL;
        end else begin
            case (state)
                IDLE:  nextState = IDLE;
                MUL:   if (mulDone) nextState = READY;
                READY: if (row_req) nextState = FETCH;
                FETCH: if (vgaIssue && col == LAST_COL) nextState = DRAIN;
                DRAIN: nextState = (rowCnt == LAST_ROW) ? IDLE : READY;
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            denyCnt <= '0;
        end else if (!cpu_req || cpuGnt) begin
            denyCnt <= '0;
        end else if (state == FETCH) begin
            denyCnt <= denyCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            levelL     <= '0;
            rowLenL    <= '0;
            xL         <= '0;
            startAddrQ <= '0;
            rowBase    <= '0;
            rowCnt     <= '0;
            col        <= '0;
            wrPend     <= 1'b0;
            wrIdx      <= '0;
            rowReadyQ  <= 1'b0;
            overrunQ   <= 1'b0;
        end else begin
            wrPend    <= vgaIssue;
            wrIdx     <= col;
            rowReadyQ <= (state == DRAIN) && !frame_start;
            if (row_req && state != READY) begin
                overrunQ <= 1'b1;
            end
            if (frame_start) begin
                levelL  <= level_addr;
                rowLenL <= row_length;
                xL      <= x_offset;
                col     <= '0;
            end else begin
                case (state)
                    MUL: begin
                        if (mulDone) begin
                            startAddrQ <= startSum;
`ifdef VGA_MAP_HWRAP_EN
                            rowBase    <= lineOrigin;
`else
                            rowBase    <= startSum;
`endif
                            rowCnt     <= '0;
                        end
                    end
                    READY: begin
                        if (row_req) begin
                            col <= '0;
                        end
                    end
                    FETCH: begin
                        if (vgaIssue) begin
                            col <= col + 6'd1;
                        end
                    end
                    DRAIN: begin
                        rowBase <= rowBase + rowLenL;
                        rowCnt  <= rowCnt + ROW_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_map_fetch_sched.sv
module tb_vga_map_fetch_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        row_req;
    logic [15:0] level_addr;
    logic [15:0] row_length;
    logic [15:0] x_offset;
    logic [15:0] y_offset;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_gnt;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        tile_wr_en;
    logic [5:0]  tile_wr_idx;
    logic [15:0] tile_wr_data;
    logic [15:0] start_addr;
    logic        row_ready;
    logic        busy;
    logic        overrun;

    int nVec = 0;
    int nErr = 0;

    vga_map_fetch_sched #(
        .TILES_X    (40),
        .TILES_Y    (30),
        .CPU_STARVE (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .row_req      (row_req),
        .level_addr   (level_addr),
        .row_length   (row_length),
        .x_offset     (x_offset),
        .y_offset     (y_offset),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_gnt      (cpu_gnt),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .tile_wr_en   (tile_wr_en),
        .tile_wr_idx  (tile_wr_idx),
        .tile_wr_data (tile_wr_data),
        .start_addr   (start_addr),
        .row_ready    (row_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Memory model: data is a fixed scramble of the address from the
    // previous cycle.
    always @(posedge clk) mem_rdata <= mem_addr ^ 16'h5A5A;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int expCol;
        int wrExp;

        reset       = 1'b1;
        frame_start = 1'b0;
        row_req     = 1'b0;
        level_addr  = '0;
        row_length  = '0;
        x_offset    = '0;
        y_offset    = '0;
        cpu_req     = 1'b0;
        cpu_addr    = '0;

        // Reset state
        #2;
        check("rst_busy",      32'(busy),        0);
        check("rst_start",     32'(start_addr),  0);
        check("rst_wr_en",     32'(tile_wr_en),  0);
        check("rst_wr_idx",    32'(tile_wr_idx), 0);
        check("rst_row_ready", 32'(row_ready),   0);
        check("rst_overrun",   32'(overrun),     0);
        check("rst_mem_addr",  32'(mem_addr),    0);
        check("rst_cpu_gnt",   32'(cpu_gnt),     0);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // 1. Start location
        level_addr  = 16'h1000;
        x_offset    = 16'd3;
        y_offset    = 16'd2;
        row_length  = 16'd64;
        frame_start = 1'b1;
        #1 check("t1_idle_busy", 32'(busy), 0);
        cyc();
        frame_start = 1'b0;
        for (int m = 1; m <= 16; m++) begin
            #1;
            check("t1_mul_busy",  32'(busy), 1);
            check("t1_mul_start", 32'(start_addr), 0);
            cyc();
        end
        #1;
        check("t1_start_addr", 32'(start_addr), 32'h1083);
        check("t1_ready_busy", 32'(busy), 0);

        // 2. Row fetch without CPU traffic
        row_req = 1'b1;
        cyc();
        row_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            check("t2_mem_addr", 32'(mem_addr), 32'(16'h1083 + 16'(i)));
            check("t2_cpu_gnt",  32'(cpu_gnt), 0);
            check("t2_wr_en",    32'(tile_wr_en), (i > 0) ? 1 : 0);
            if (i > 0) begin
                check("t2_wr_idx",  32'(tile_wr_idx), 32'(i - 1));
                check("t2_wr_data", 32'(tile_wr_data), 32'((16'h1083 + 16'(i - 1)) ^ 16'h5A5A));
            end
            cyc();
        end
        #1;
        check("t2_drain_wr_en", 32'(tile_wr_en), 1);
        check("t2_drain_idx",   32'(tile_wr_idx), 39);
        check("t2_drain_data",  32'(tile_wr_data), 32'(16'h10AA ^ 16'h5A5A));
        check("t2_drain_rr",    32'(row_ready), 0);
        check("t2_drain_busy",  32'(busy), 1);
        cyc();
        #1;
        check("t2_row_ready", 32'(row_ready), 1);
        check("t2_rr_busy",   32'(busy), 0);
        check("t2_rr_wr_en",  32'(tile_wr_en), 0);

        // 3. Starvation guard, cpu_req held through the burst
        row_req  = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 16'hBEEF;
        #1;
        check("t3_ready_gnt",  32'(cpu_gnt), 1);
        check("t3_ready_addr", 32'(mem_addr), 32'hBEEF);
        cyc();
        row_req = 1'b0;
        expCol  = 0;
        wrExp   = 0;
        for (int k = 1; k <= 44; k++) begin
            #1;
            if (k % 9 == 0) begin
                check("t3_gnt",      32'(cpu_gnt), 1);
                check("t3_cpu_addr", 32'(mem_addr), 32'hBEEF);
            end else begin
                check("t3_gnt",      32'(cpu_gnt), 0);
                check("t3_vga_addr", 32'(mem_addr), 32'(16'h10C3 + 16'(expCol)));
                expCol++;
            end
            if (tile_wr_en) begin
                check("t3_wr_idx", 32'(tile_wr_idx), 32'(wrExp));
                wrExp++;
            end
            cyc();
        end
        cpu_req = 1'b0;
        #1;
        check("t3_drain_busy", 32'(busy), 1);
        if (tile_wr_en) begin
            check("t3_wr_idx", 32'(tile_wr_idx), 32'(wrExp));
            wrExp++;
        end
        check("t3_total_writes", 32'(wrExp), 40);
        cyc();
        #1;
        check("t3_row_ready", 32'(row_ready), 1);

        // 4. Abort at col 20 of the third row
        row_req = 1'b1;
        cyc();
        row_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1 check("t4_mem_addr", 32'(mem_addr), 32'(16'h1103 + 16'(i)));
            cyc();
        end
        level_addr  = 16'h2000;
        x_offset    = 16'd5;
        y_offset    = 16'd3;
        row_length  = 16'd100;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        for (int m = 1; m <= 16; m++) begin
            #1;
            check("t4_no_wr",   32'(tile_wr_en), 0);
            check("t4_mul_busy", 32'(busy), 1);
            cyc();
        end
        #1;
        check("t4_start_addr", 32'(start_addr), 32'h2131);
        check("t4_busy",       32'(busy), 0);
        check("t4_no_wr_end",  32'(tile_wr_en), 0);
        check("t4_no_rr",      32'(row_ready), 0);

        // 5. Overrun, then async reset mid-FETCH
        check("t5_overrun_pre", 32'(overrun), 0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        for (int m = 1; m <= 16; m++) begin
            if (m == 3) row_req = 1'b1;
            if (m == 4) row_req = 1'b0;
            #1;
            check("t5_overrun", 32'(overrun), (m >= 4) ? 1 : 0);
            check("t5_mul_busy", 32'(busy), 1);
            cyc();
        end
        #1;
        check("t5_busy",       32'(busy), 0);
        check("t5_start_addr", 32'(start_addr), 32'h2131);
        check("t5_sticky",     32'(overrun), 1);
        row_req = 1'b1;
        cyc();
        row_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1 check("t5_mem_addr", 32'(mem_addr), 32'(16'h2131 + 16'(i)));
            cyc();
        end
        #1 check("t5_mid_wr_en", 32'(tile_wr_en), 1);
        #1 reset = 1'b1;
        #1;
        check("t5_rst_wr_en",   32'(tile_wr_en), 0);
        check("t5_rst_busy",    32'(busy), 0);
        check("t5_rst_start",   32'(start_addr), 0);
        check("t5_rst_overrun", 32'(overrun), 0);
        check("t5_rst_mem",     32'(mem_addr), 0);
        check("t5_rst_idx",     32'(tile_wr_idx), 0);
        for (int c = 0; c < 2; c++) begin
            cyc();
            check("t5_rst_hold_wr", 32'(tile_wr_en), 0);
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            check("t5_post_wr",   32'(tile_wr_en), 0);
            check("t5_post_busy", 32'(busy), 0);
            check("t5_post_rr",   32'(row_ready), 0);
        end

`ifdef VGA_MAP_HWRAP_EN
        // 6. Horizontal wrap within the level row
        level_addr  = 16'h0400;
        x_offset    = 16'd60;
        y_offset    = 16'd1;
        row_length  = 16'd64;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        for (int m = 1; m <= 16; m++) cyc();
        #1 check("t6_start_addr", 32'(start_addr), 32'h047C);
        row_req = 1'b1;
        cyc();
        row_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1 check("t6_wrap_addr", 32'(mem_addr), 32'(16'h0440 + 16'((60 + i) % 64)));
            cyc();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
